// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus (CDB) among the functional units (0=alu, 1=mul, 2=div, 3=br,
//   4=mem). Each unit owns a one-entry holding slot. One slot is granted per cycle and the CDB is
//   driven from registered outputs.
//
// Configuration macro:
//   CDB_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins, no rr pointer
//                          undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous pipeline flush, drops all held results
//   req_valid/ready per-unit handshake into the holding slots
//   req_data, req_rob_idx, req_rd_addr, req_regf_we   packed per-unit payloads
//   cdb_valid, cdb_data, cdb_rob_idx, cdb_rd_addr, cdb_regf_we   registered broadcast
//   cdb_src         one-hot source of the current broadcast
module cdb_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5,
    parameter int REG_W     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*REG_W-1:0]       req_rd_addr,
    input  logic [NUM_REQ-1:0]             req_regf_we,
    output logic                           cdb_valid,
    output logic [DATA_W-1:0]              cdb_data,
    output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
    output logic [REG_W-1:0]               cdb_rd_addr,
    output logic                           cdb_regf_we,
    output logic [NUM_REQ-1:0]             cdb_src
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Holding slots
    logic [NUM_REQ-1:0]    r_slot_valid;
    logic [DATA_W-1:0]     r_slot_data   [NUM_REQ];
    logic [ROB_IDX_W-1:0]  r_slot_rob    [NUM_REQ];
    logic [REG_W-1:0]      r_slot_rd     [NUM_REQ];
    logic [NUM_REQ-1:0]    r_slot_we;

    // Broadcast registers
    logic                  r_cdb_valid;
    logic [DATA_W-1:0]     r_cdb_data;
    logic [ROB_IDX_W-1:0]  r_cdb_rob;
    logic [REG_W-1:0]      r_cdb_rd;
    logic                  r_cdb_we;
    logic [NUM_REQ-1:0]    r_cdb_src;

    // Arbitration
    logic                  w_found;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_do_grant;
    logic [NUM_REQ-1:0]    w_accept;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is the last one written.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_slot_valid[i]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_rr_next;

    // Search starts at r_rr_ptr and wraps; the first valid slot wins.
    always_comb begin
        automatic int         cand;
        automatic logic [PTR_W-1:0] cand_idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!w_found && r_slot_valid[cand_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = cand_idx;
            end
        end
    end

    assign w_rr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_do_grant) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`endif

    assign w_grant    = w_found ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    // Flush suppresses the grant so a discarded result never reaches the bus.
    assign w_do_grant = w_found && !flush;

    // A slot being drained this cycle may be refilled at the same edge.
    assign req_ready = {NUM_REQ{!flush}} & (~r_slot_valid | w_grant);
    assign w_accept  = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_slot_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot_valid[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind r_slot_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && w_accept[i]) begin
                r_slot_data[i] <= req_data[i*DATA_W +: DATA_W];
                r_slot_rob[i]  <= req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                r_slot_rd[i]   <= req_rd_addr[i*REG_W +: REG_W];
                r_slot_we[i]   <= req_regf_we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_rob   <= '0;
            r_cdb_rd    <= '0;
            r_cdb_we    <= 1'b0;
            r_cdb_src   <= '0;
        end else if (w_do_grant) begin
            r_cdb_valid <= 1'b1;
            r_cdb_data  <= r_slot_data[w_gnt_idx];
            r_cdb_rob   <= r_slot_rob[w_gnt_idx];
            r_cdb_rd    <= r_slot_rd[w_gnt_idx];
            r_cdb_we    <= r_slot_we[w_gnt_idx];
            r_cdb_src   <= w_grant;
        end else begin
            // Payload fields hold their last broadcast value.
            r_cdb_valid <= 1'b0;
            r_cdb_src   <= '0;
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_data    = r_cdb_data;
    assign cdb_rob_idx = r_cdb_rob;
    assign cdb_rd_addr = r_cdb_rd;
    assign cdb_regf_we = r_cdb_we;
    assign cdb_src     = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic, all checked against a
// slot/queue-level reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic [N*RW-1:0] req_rob_idx;
    logic [N*AW-1:0] req_rd_addr;
    logic [N-1:0]    req_regf_we;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_data;
    logic [RW-1:0]   cdb_rob_idx;
    logic [AW-1:0]   cdb_rd_addr;
    logic            cdb_regf_we;
    logic [N-1:0]    cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .ROB_IDX_W (RW),
        .REG_W     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_rob_idx (req_rob_idx),
        .req_rd_addr (req_rd_addr),
        .req_regf_we (req_regf_we),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_rob_idx (cdb_rob_idx),
        .cdb_rd_addr (cdb_rd_addr),
        .cdb_regf_we (cdb_regf_we),
        .cdb_src     (cdb_src)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending results per unit, a search start index, and the expected bus.
    bit          m_valid [N];
    logic [31:0] m_data  [N];
    logic [4:0]  m_rob   [N];
    logic [4:0]  m_rd    [N];
    bit          m_we    [N];
    int          m_start;
    bit          m_cv;
    logic [31:0] m_cd;
    logic [4:0]  m_crob;
    logic [4:0]  m_crd;
    bit          m_cwe;
    logic [N-1:0] m_csrc;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_start + k) % N]) return (m_start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_start = 0;
        m_cv = 0; m_cd = 0; m_crob = 0; m_crd = 0; m_cwe = 0; m_csrc = '0;
    endtask

    // Inputs are already driven (just after a negedge). Checks ready, applies one clock edge to
    // the model and checks the registered bus after the edge; returns at the next negedge.
    task automatic step();
        int w;
        logic [N-1:0] exp_ready;
        #1;
        w = pick();
        for (int i = 0; i < N; i++) exp_ready[i] = !flush && (!m_valid[i] || w == i);
        check_eq("req_ready", {59'd0, req_ready}, {59'd0, exp_ready});
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_cv = 0; m_csrc = '0;
        end else begin
            if (w >= 0) begin
                m_cv = 1; m_cd = m_data[w]; m_crob = m_rob[w]; m_crd = m_rd[w]; m_cwe = m_we[w];
                m_csrc = '0; m_csrc[w] = 1'b1;
`ifndef CDB_ARB_FIXED_PRIO_EN
                m_start = (w + 1) % N;
`endif
            end else begin
                m_cv = 0; m_csrc = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && exp_ready[i]) begin
                    m_valid[i] = 1;
                    m_data[i]  = req_data[i*DW +: DW];
                    m_rob[i]   = req_rob_idx[i*RW +: RW];
                    m_rd[i]    = req_rd_addr[i*AW +: AW];
                    m_we[i]    = req_regf_we[i];
                end else if (w == i) begin
                    m_valid[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("cdb_valid",   {63'd0, cdb_valid},   {63'd0, m_cv});
        check_eq("cdb_src",     {59'd0, cdb_src},     {59'd0, m_csrc});
        check_eq("cdb_data",    {32'd0, cdb_data},    {32'd0, m_cd});
        check_eq("cdb_rob_idx", {59'd0, cdb_rob_idx}, {59'd0, m_crob});
        check_eq("cdb_rd_addr", {59'd0, cdb_rd_addr}, {59'd0, m_crd});
        check_eq("cdb_regf_we", {63'd0, cdb_regf_we}, {63'd0, m_cwe});
        @(negedge clk);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW]    = $urandom;
            req_rob_idx[i*RW +: RW] = RW'($urandom_range(0, 31));
            req_rd_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
            req_regf_we[i]          = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        rst = 0; flush = 0; req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; req_valid = '0;
        step();
        rst = 0;
    endtask

    initial begin
        bit seen_div;
        rst = 1; flush = 0; req_valid = '0;
        rand_payload();
        // Bring the DUT to a known state before any comparison.
        @(posedge clk); @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset with all units requesting; first broadcast two cycles after release.
        rst = 1; req_valid = 5'b11111;
        step();
        step();
        check_eq("rst_valid", {63'd0, cdb_valid}, 64'd0);
        check_eq("rst_src",   {59'd0, cdb_src},   64'd0);
        check_eq("rst_data",  {32'd0, cdb_data},  64'd0);
        rst = 0;
        step();
        check_eq("rst_lat_1", {63'd0, cdb_valid}, 64'd0);
        step();
        check_eq("rst_lat_2", {63'd0, cdb_valid}, 64'd1);
        idle(8);

        // Single result from mul.
        req_valid = 5'b00010;
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        req_rob_idx[1*RW +: RW] = 5'd7;
        req_rd_addr[1*AW +: AW] = 5'd3;
        req_regf_we[1] = 1'b1;
        step();
        check_eq("single_accept_edge", {63'd0, cdb_valid}, 64'd0);
        req_valid = '0;
        step();
        check_eq("single_valid", {63'd0, cdb_valid},   64'd1);
        check_eq("single_data",  {32'd0, cdb_data},    64'hDEADBEEF);
        check_eq("single_rob",   {59'd0, cdb_rob_idx}, 64'd7);
        check_eq("single_rd",    {59'd0, cdb_rd_addr}, 64'd3);
        check_eq("single_we",    {63'd0, cdb_regf_we}, 64'd1);
        check_eq("single_src",   {59'd0, cdb_src},     64'b00010);
        step();
        check_eq("single_pulse", {63'd0, cdb_valid}, 64'd0);

        // All units at once from a fresh pointer.
        do_reset();
        rand_payload();
        req_valid = 5'b11111;
        step();
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            step();
            check_eq("rr_src", {59'd0, cdb_src}, 64'd1 << k);
        end
        step();
        check_eq("rr_done", {63'd0, cdb_valid}, 64'd0);

        // Streaming from alu.
        req_valid = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            rand_payload();
            step();
            check_eq("stream_ready0", {63'd0, req_ready[0]}, 64'd1);
            if (k > 0) check_eq("stream_src", {59'd0, cdb_src}, 64'b00001);
        end
        req_valid = '0;
        step();
        check_eq("stream_last", {59'd0, cdb_src}, 64'b00001);
        step();
        check_eq("stream_end", {63'd0, cdb_valid}, 64'd0);

        // Contention: alu streams while div waits.
        do_reset();
        rand_payload();
        req_valid = 5'b00101;
        step();
        req_valid = 5'b00001;
        seen_div = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (cdb_src == 5'b00100) seen_div = 1;
        end
`ifdef CDB_ARB_FIXED_PRIO_EN
        check_eq("contention_div", {63'd0, seen_div}, 64'd0);
`else
        check_eq("contention_div", {63'd0, seen_div}, 64'd1);
`endif
        idle(6);

        // Flush with three held results and new requests in the flush cycle.
        rand_payload();
        req_valid = 5'b00111;
        step();
        flush = 1; req_valid = 5'b11111;
        step();
        check_eq("flush_valid", {63'd0, cdb_valid}, 64'd0);
        flush = 0; req_valid = '0;
        #1;
        check_eq("flush_ready", {59'd0, req_ready}, 64'b11111);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("flush_no_bcast", {63'd0, cdb_valid}, 64'd0);
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 24) == 0);
            req_valid = (c % 2 == 0) ? N'($urandom) : N'($urandom & $urandom);
            rand_payload();
            step();
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
